leddc_tx: RTL and testbench
===========================

# leddc_tx

Serial pixel-data transmitter for the LED display driver's input port. Accepts 16-bit gray-level words over a valid/ready stream, buffers them, and shifts each word out LSB-first on DAI with a generated DCK and a word-framing DEN, in the exact format the display driver's DCK-domain receiver shifts into its 16-bit write register. Sits on the host/controller side, upstream of the driver, one instance per driver chain.

## Interface

- `DIV`, 4: clk cycles per DCK period. Even, ≥2.
- `FRAME_WORDS`, 256: words sent per frame (16 channels × 16 scanlines).
- `FIFO_DEPTH`, 4: input buffer depth, power of two. Used only with `LEDDC_TX_FIFO_EN`.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_data` input 16: pixel word.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: buffer can accept a word. A transfer occurs when `in_valid` and `in_ready` are both high on a clk edge.
- `frame_start` input 1: one-cycle pulse that begins a frame.
- `DCK` output 1: serial data clock to driver.
- `DAI` output 1: serial data.
- `DEN` output 1: data enable, high for exactly 16 consecutive DCK rising edges per word.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse at frame end.
- `underrun` output 1: sticky flag, buffer empty at a word boundary during the frame.

## Operation

- Reset values: `DCK`=0, `DAI`=0, `DEN`=0, `busy`=0, `done`=0, `underrun`=0, `in_ready`=0 while `rst` is high and 1 after release. Buffer emptied; bit and word counters 0; state IDLE. An assertion of `rst` mid-frame aborts the frame immediately, and any partial word is discarded.
- Buffer: `in_ready` = not full, independent of frame state, so the host can prefill before `frame_start`. A word loaded while full is not accepted.
- States:
  - IDLE: `DCK` held 0. On `frame_start`, go to RUN, set `busy`, clear `underrun`, clear word count.
  - RUN: phase counter `ph` runs 0..DIV-1. `DCK` is 1 for `ph` in DIV/2..DIV-1. The launch point is `ph`==0, the clk edge on which `DCK` falls or stays low.
  - At each launch point:
    - Mid-word: drive the next bit.
    - At a word boundary with the buffer non-empty: pop a word, `DEN`=1, `DAI`=bit0, bit count 0.
    - At a word boundary with the buffer empty: `DEN`=0, `DAI`=0, set `underrun`.
  - After bit 15 of word FRAME_WORDS-1 has been sampled, go to DONE at the next launch point.
  - DONE: `DEN`=0, `DAI`=0, `DCK`=0. Pulse `done` for one cycle, clear `busy`, return to IDLE.
- Bit order: bit 0 first, bit 15 last. The receiver's right-shift register then holds the word unchanged.
- `frame_start` while `busy` is ignored. Words beyond FRAME_WORDS remain buffered for the next frame.
- Word count width is clog2(FRAME_WORDS). It stops at FRAME_WORDS-1 and does not wrap within a frame.

## Timing

- From `frame_start` sampled on edge N:
  - If the buffer is non-empty, `DEN`=1 and `DAI`=bit0 are registered at edge N+1.
  - The first `DCK` rise is at edge N+1+DIV/2.
- `DAI` and `DEN` change only at launch points. They are stable for DIV/2 clk cycles before and after each `DCK` rising edge.
- A word occupies 16×DIV clk cycles. With no underrun, `DEN` stays high across consecutive words; the receiver's 0..15 counter wraps seamlessly.
- An underrun gap is a whole number of DCK periods, with `DEN` low for every rising edge in the gap. Data resumes at the first launch point after a word becomes available.
- `done` is asserted DIV/2 cycles after the final `DCK` fall, i.e. one full DCK period after the last rising edge.
- `busy` falls together with `done`.

## Configuration

- `LEDDC_TX_FIFO_EN` defined: the buffer is a FIFO_DEPTH-entry circular FIFO. A simultaneous push and pop when full is allowed: the pop frees a slot and the push is accepted in the same cycle.
- `LEDDC_TX_FIFO_EN` undefined: the buffer is a single holding register, so `in_ready`=0 while it is occupied. It is freed at the launch point that loads its word into the shifter. Behaviour is otherwise identical.

## Test plan

- Reset: assert `rst` mid-frame (DIV=4) → all outputs reach their reset values in the same cycle, with no clk edge required; after release `in_ready`=1 and `busy`=0.
- Basic frame (FRAME_WORDS=2, DIV=4): prefill 0xA5C3 and 0x0001, pulse `frame_start` → `DAI` at successive DCK rises is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 then 1 followed by 15 zeros; `DEN` is high for 32 rises; `done` pulses once; `underrun`=0.
- Underrun: provide word 2 twenty cycles late → `DEN` is low for ≥1 full DCK period, `underrun`=1, and the late word is still transmitted intact.
- Backpressure (FIFO_EN, depth 4): hold `in_valid` with `frame_start` low → exactly 4 words are accepted, then `in_ready`=0. The 5th word is accepted on the first pop.
- `frame_start` pulsed while `busy` → no restart and the word count is unaffected; a new `frame_start` after `done` starts a fresh frame and clears `underrun`.
- Loopback: feed `DCK`/`DAI`/`DEN` into a receiver shift-register model; 256 random words → every captured word matches, in order.

Source files
------------

// File: rtl/leddc_tx.sv
// Serial pixel-data transmitter: buffers 16-bit words and shifts them LSB-first on DAI/DCK/DEN.
// Optional feature macro LEDDC_TX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of a single holding register.
module leddc_tx #(
  parameter int DIV         = 4,
  parameter int FRAME_WORDS = 256,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        frame_start,
  output logic        DCK,
  output logic        DAI,
  output logic        DEN,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam int PHW = $clog2(DIV);
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [PHW-1:0] PH_LAST = PHW'(DIV - 1);
  localparam logic [PHW-1:0] PH_HALF = PHW'(DIV / 2);
  localparam logic [WCW-1:0] WC_LAST = WCW'(FRAME_WORDS - 1);

  if (DIV < 2 || (DIV % 2) != 0 || FRAME_WORDS < 1 ||
      FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("leddc_tx: DIV must be even >= 2, FIFO_DEPTH a power of two");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

  state_t         state, state_d;
  logic [PHW-1:0] ph;
  logic [3:0]     bit_cnt;
  logic [WCW-1:0] word_cnt;
  logic [14:0]    sh;
  logic           push, pop, buf_empty;
  logic [15:0]    buf_data;
  logic           launch, word_end, boundary, last_end;

`ifdef LEDDC_TX_FIFO_EN
  localparam int IW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [15:0]   mem [FIFO_DEPTH];
  logic [IW-1:0] wr_idx, rd_idx;
  logic [CW-1:0] count;
  logic          buf_full;

  assign buf_full  = (count == CW'(FIFO_DEPTH));
  assign buf_empty = (count == '0);
  assign buf_data  = mem[rd_idx];
  // A pop in the same cycle frees a slot, so a full FIFO can still take a word then.
  assign in_ready  = !rst && (!buf_full || pop);
  assign push      = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= (wr_idx == IW'(FIFO_DEPTH - 1)) ? '0 : wr_idx + 1'b1;
      if (pop)  rd_idx <= (rd_idx == IW'(FIFO_DEPTH - 1)) ? '0 : rd_idx + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= in_data;
  end
`else
  logic [15:0] hold;
  logic        hold_full;

  assign buf_empty = !hold_full;
  assign buf_data  = hold;
  assign in_ready  = !rst && !hold_full;
  assign push      = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (push) begin
      hold      <= in_data;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end
`endif

  assign launch   = (state == RUN) && (ph == '0);
  assign word_end = DEN && (bit_cnt == 4'd15);
  assign boundary = !DEN || word_end;
  assign last_end = word_end && (word_cnt == WC_LAST);
  assign pop      = launch && boundary && !last_end && !buf_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // FLUSH holds the line idle for half a DCK period after the last fall before done pulses.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (frame_start) state_d = RUN;
      RUN:     if (launch && last_end) state_d = FLUSH;
      FLUSH:   if (ph == PH_HALF) state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FLUSH);
    done = (state == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph       <= '0;
      DCK      <= 1'b0;
      DAI      <= 1'b0;
      DEN      <= 1'b0;
      underrun <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      sh       <= '0;
    end else begin
      DCK <= (state == RUN) && (ph >= PH_HALF);
      if (state == RUN || state == FLUSH) ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
      else                                ph <= '0;
      if (state == IDLE && frame_start) begin
        underrun <= 1'b0;
        word_cnt <= '0;
        bit_cnt  <= '0;
      end else if (launch) begin
        if (!boundary) begin
          DAI     <= sh[0];
          sh      <= sh >> 1;
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          if (word_end && !last_end) word_cnt <= word_cnt + 1'b1;
          if (last_end) begin
            DEN <= 1'b0;
            DAI <= 1'b0;
          end else if (!buf_empty) begin
            DEN     <= 1'b1;
            DAI     <= buf_data[0];
            sh      <= buf_data[15:1];
            bit_cnt <= '0;
          end else begin
            DEN      <= 1'b0;
            DAI      <= 1'b0;
            underrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_leddc_tx.sv
// Directed bench for leddc_tx: expected words queued on acceptance, compared against
// a DCK-domain receiver model capturing DAI while DEN is high.
module tb_leddc_tx;

  localparam int DIV    = 4;
  localparam int FW     = 2;
  localparam int DEPTH  = 4;
  localparam int CLK_NS = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, in_ready, frame_start;
  logic        dck, dai, den, busy, done, underrun;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expQ[$];
  logic [15:0] capQ[$];
  logic [1:0]  riseLog[$];
  int          capRd = 0;
  logic [15:0] rxShift = '0;
  int          rxCnt = 0;
  int          doneCnt = 0;
  time         lastRiseT = 0;
  time         doneT = 0;

  leddc_tx #(.DIV(DIV), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .frame_start(frame_start), .DCK(dck), .DAI(dai), .DEN(den),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #(CLK_NS/2) clk = ~clk;

  // Receiver model: right-shift register clocked by DCK, word complete after 16 enabled rises.
  always @(posedge dck or posedge rst) begin
    if (rst) begin
      rxCnt = 0;
    end else begin
      riseLog.push_back({den, dai});
      lastRiseT = $time;
      if (den) begin
        rxShift = {dai, rxShift[15:1]};
        rxCnt++;
        if (rxCnt == 16) begin
          capQ.push_back(rxShift);
          rxCnt = 0;
        end
      end
    end
  end

  always @(negedge clk) if (done) doneCnt++;
  always @(posedge done) doneT = $time;

  function automatic int countRises(input int from, input logic wantDen);
    int n = 0;
    for (int i = from; i < riseLog.size(); i++) if (riseLog[i][1] == wantDen) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] w);
    int n = 0;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept", 32'(in_ready), 32'd1);
    if (in_ready) begin
      @(posedge clk);
      expQ.push_back(w);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(n < 3000), 32'd1);
    @(negedge clk);
  endtask

  task automatic checkCaptured();
    logic [15:0] e;
    while (capRd < capQ.size()) begin
      e = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
      checkOutput("rx_word", 32'(capQ[capRd]), 32'(e));
      capRd++;
    end
  endtask

  initial begin
    int          r0, d0;
    logic [31:0] stream;
    logic [15:0] a, b;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    checkOutput("reset_vals", 32'({in_ready, dck, dai, den, busy, done, underrun}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("post_reset", 32'({in_ready, busy}), 32'b10);

    // Mid-frame asynchronous reset
    applyStimulus(16'hFFFF);
    pulseStart();
    repeat (6) @(negedge clk);
    checkOutput("midframe_active", 32'({busy, den, dai}), 32'b111);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", 32'({in_ready, dck, dai, den, busy, done, underrun}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("reset_release", 32'({in_ready, busy, den, underrun}), 32'b1000);
    expQ.delete();

    // Basic two-word frame
    applyStimulus(16'hA5C3);
    r0 = riseLog.size();
    d0 = doneCnt;
    pulseStart();
    checkOutput("start_den0", 32'({busy, den}), 32'b10);
    @(negedge clk);
    checkOutput("first_launch", 32'({den, dai, dck}), 32'b110);
    @(negedge clk);
    checkOutput("dck_low", 32'(dck), 32'd0);
    @(negedge clk);
    checkOutput("dck_first_rise", 32'(dck), 32'd1);
    applyStimulus(16'h0001);
    waitDone();
    stream = {16'h0001, 16'hA5C3};
    checkOutput("basic_rises", 32'(riseLog.size() - r0), 32'd32);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("basic_bit%0d", i), 32'(riseLog[r0 + i]), 32'({1'b1, stream[i]}));
    checkOutput("basic_done_once", 32'(doneCnt - d0), 32'd1);
    checkOutput("done_latency", 32'(doneT - lastRiseT), 32'(DIV * CLK_NS));
    checkOutput("basic_idle", 32'({busy, underrun, den}), 32'd0);
    checkCaptured();

    // Underrun with a late second word, plus an ignored frame_start while busy
    applyStimulus(16'h1234);
    r0 = riseLog.size();
    d0 = doneCnt;
    pulseStart();
    repeat (30) @(negedge clk);
    pulseStart();
    checkOutput("busy_restart_ignored", 32'(busy), 32'd1);
    repeat (50) @(negedge clk);
    checkOutput("underrun_set", 32'({underrun, den}), 32'b10);
    applyStimulus(16'hBEEF);
    waitDone();
    checkOutput("underrun_sticky", 32'({underrun, busy}), 32'b10);
    checkOutput("underrun_high_rises", 32'(countRises(r0, 1'b1)), 32'd32);
    checkOutput("underrun_gap", 32'(countRises(r0, 1'b0) >= 1), 32'd1);
    checkOutput("underrun_done_once", 32'(doneCnt - d0), 32'd1);
    checkCaptured();

`ifdef LEDDC_TX_FIFO_EN
    // Backpressure: four words fill the FIFO, the fifth is taken on the first pop
    for (int k = 0; k < 4; k++) applyStimulus(16'h1000 + 16'(k));
    @(negedge clk);
    in_data = 16'h1004; in_valid = 1'b1;
    checkOutput("fifo_full", 32'(in_ready), 32'd0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checkOutput("fifo_pop_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    expQ.push_back(16'h1004);
    #1 in_valid = 1'b0;
    waitDone();
    checkCaptured();
    pulseStart();
    waitDone();
    checkCaptured();
    applyStimulus(16'h1005);
    pulseStart();
    waitDone();
    checkCaptured();
`else
    // Backpressure: the holding register blocks a second word until it is loaded
    applyStimulus(16'h2000);
    @(negedge clk);
    checkOutput("hold_full", 32'(in_ready), 32'd0);
    pulseStart();
    applyStimulus(16'h2001);
    waitDone();
    checkCaptured();
`endif

    // Loopback of 256 random words; each new frame must clear underrun
    for (int f = 0; f < 128; f++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      applyStimulus(a);
      pulseStart();
      checkOutput("start_clears_underrun", 32'(underrun), 32'd0);
      applyStimulus(b);
      waitDone();
      checkCaptured();
    end
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
